if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 The block SHALL have ports: clk  input  1  single clock, all state updates on its rising edge.
REQ-002 The block SHALL have ports: rst  input  1  reset, synchronous and active-high.
REQ-003 The block SHALL have ports: stall  input  1  hold request from ID hazard logic (load-use).
REQ-004 The block SHALL have ports: branch_taken  input  1  redirect request from EX.
REQ-005 The block SHALL have ports: branch_target  input  PC_LEN  redirect address.
REQ-006 The block SHALL have ports: halt_req  input  1  stop-fetch request from ID.
REQ-007 The block SHALL have ports: imem_addr  output  PC_LEN  instruction memory address, equal to PC register.
REQ-008 The block SHALL have ports: imem_data  input  INSTRUCTION_LEN  combinational instruction memory read data.
REQ-009 The block SHALL have ports: PR1_instruction  output  INSTRUCTION_LEN  IF/ID instruction to the decode stage.
REQ-010 The block SHALL have ports: PR1_PC  output  PC_LEN  PC of PR1_instruction.
REQ-011 The block SHALL have ports: PR1_valid  output  1  PR1_instruction is a real fetched instruction.
REQ-012 The block SHALL have ports: halted  output  1  FSM is in HALT.
REQ-013 Parameter PC_LEN, default 12, SHALL set the word-address PC width.

Function
REQ-014 FSM states SHALL be BOOT, RUN and HALT.
REQ-015 BOOT SHALL last exactly one cycle after rst deasserts, then go to RUN; in BOOT the PC SHALL hold 0 and PR1 SHALL load a bubble.
REQ-016 A bubble SHALL be PR1_instruction = NOP (all zeros), PR1_PC = 0 and PR1_valid = 0.
REQ-017 The RUN priority order SHALL be branch_taken > halt_req > stall > normal fetch.
REQ-018 Normal fetch SHALL load PR1 with {imem_data, PC, valid = 1} and set PC <= PC + 1, giving one-cycle latency from PC to PR1.
REQ-019 PC increment SHALL wrap modulo 2^PC_LEN, so all-ones is followed by 0 with no flag.
REQ-020 Stall SHALL hold PC and all PR1 outputs unchanged.
REQ-021 branch_taken SHALL set PC <= branch_target and load a bubble into PR1 (flush), regardless of stall or halt_req in the same cycle.
REQ-022 halt_req (with no branch_taken) SHALL load a bubble into PR1, hold PC, and move the FSM to HALT; stall in the same cycle SHALL be ignored.
REQ-023 In HALT, PC SHALL be frozen, PR1 SHALL load a bubble every cycle, all of stall, branch_taken and halt_req SHALL be ignored, and exit SHALL be by rst only.
REQ-024 halted SHALL be 1 exactly while the FSM is in HALT.
REQ-025 imem_addr SHALL be combinational from the PC register only and SHALL NOT depend on any input of the same cycle.

Reset
REQ-026 rst, sampled on the clk edge, SHALL override all other inputs and set PC = 0, PR1_instruction = 0, PR1_PC = 0, PR1_valid = 0, FSM = BOOT and halted = 0.
REQ-027 rst asserted mid-stall, mid-branch or in HALT SHALL give the same result as reset from power-up.

Structure
REQ-028 PC_LEN default, the NOP encoding and the FSM state enum SHALL live in the shared defines/package alongside INSTRUCTION_LEN and WORD_LEN.
REQ-029 The PC register with its load, hold and increment logic SHALL be a sub-module named pc_reg; the IF/ID register and FSM SHALL stay in if_stage.

Verification
REQ-030 Reset then release, imem returns mem[a] = a + 0x100 -> cycle 1 after release gives a bubble; cycles 2..4 give PR1_PC = 0, 1, 2 with instructions 0x100, 0x101, 0x102 and valid = 1.
REQ-031 stall held 2 cycles while PC = 5 -> PR1_PC stays at 4 and imem_addr stays at 5 for 2 cycles, then fetch resumes at 5.
REQ-032 branch_taken and stall both high, target 0x3A -> next cycle gives a PR1 bubble and imem_addr = 0x3A, and the cycle after gives PR1_PC = 0x3A.
REQ-033 PC preset to 0xFFF (PC_LEN = 12) via branch -> next fetch has imem_addr = 0x000 and PR1_PC = 0xFFF.
REQ-034 halt_req at PC = 8 -> halted = 1 the next cycle, PC frozen at 8, bubbles continue, later branch_taken is ignored, and rst returns the FSM to BOOT.
REQ-035 rst pulsed during a stall with PR1_valid = 1 -> the next cycle gives all outputs 0 and imem_addr = 0.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: widths, NOP encoding and the fetch FSM states.
// Imported by pc_reg and if_stage.
package if_stage_pkg;

    localparam int INSTRUCTION_LEN = 32;
    localparam int WORD_LEN        = 32;
    localparam int PC_LEN_DEF      = 12;

    localparam logic [INSTRUCTION_LEN-1:0] NOP = '0;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: synchronous clear, load, hold or wrap-around increment.
// Ports: clk, rst, load_i (take target_i), hold_i (keep value), target_i, pc_o.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter int PC_LEN = PC_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              hold_i,
    input  logic [PC_LEN-1:0] target_i,
    output logic [PC_LEN-1:0] pc_o
);

    logic [PC_LEN-1:0] pc_q;
    logic [PC_LEN-1:0] pc_d;

    // Load beats hold; plain increment wraps naturally at all-ones.
    always_comb begin
        pc_d = pc_q + 1'b1;
        if (load_i) begin
            pc_d = target_i;
        end else if (hold_i) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC control, IF/ID register and BOOT/RUN/HALT FSM.
// Ports: clk, rst, stall, branch_taken, branch_target, halt_req, imem_addr,
//        imem_data, PR1_instruction, PR1_PC, PR1_valid, halted.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int PC_LEN = PC_LEN_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       branch_taken,
    input  logic [PC_LEN-1:0]          branch_target,
    input  logic                       halt_req,
    output logic [PC_LEN-1:0]          imem_addr,
    input  logic [INSTRUCTION_LEN-1:0] imem_data,
    output logic [INSTRUCTION_LEN-1:0] PR1_instruction,
    output logic [PC_LEN-1:0]          PR1_PC,
    output logic                       PR1_valid,
    output logic                       halted
);

    fetch_state_e               state_q;
    logic                       halted_q;
    logic [INSTRUCTION_LEN-1:0] instr_q;
    logic [PC_LEN-1:0]          pr1_pc_q;
    logic                       valid_q;

    logic              pc_load;
    logic              pc_hold;
    logic [PC_LEN-1:0] pc;

    // PC only advances on a plain RUN fetch; branch loads, all else holds.
    always_comb begin
        pc_load = 1'b0;
        pc_hold = 1'b1;
        if (state_q == RUN) begin
            if (branch_taken) begin
                pc_load = 1'b1;
            end else if (!halt_req && !stall) begin
                pc_hold = 1'b0;
            end
        end
    end

    pc_reg #(
        .PC_LEN   (PC_LEN)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (pc_load),
        .hold_i   (pc_hold),
        .target_i (branch_target),
        .pc_o     (pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BOOT;
            halted_q <= 1'b0;
            instr_q  <= NOP;
            pr1_pc_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            case (state_q)
                BOOT: begin
                    state_q  <= RUN;
                    instr_q  <= NOP;
                    pr1_pc_q <= '0;
                    valid_q  <= 1'b0;
                end
                RUN: begin
                    if (branch_taken) begin
                        instr_q  <= NOP;
                        pr1_pc_q <= '0;
                        valid_q  <= 1'b0;
                    end else if (halt_req) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                        instr_q  <= NOP;
                        pr1_pc_q <= '0;
                        valid_q  <= 1'b0;
                    end else if (!stall) begin
                        instr_q  <= imem_data;
                        pr1_pc_q <= pc;
                        valid_q  <= 1'b1;
                    end
                end
                HALT: begin
                    instr_q  <= NOP;
                    pr1_pc_q <= '0;
                    valid_q  <= 1'b0;
                end
                default: begin
                    state_q  <= BOOT;
                    halted_q <= 1'b0;
                    instr_q  <= NOP;
                    pr1_pc_q <= '0;
                    valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr       = pc;
    assign PR1_instruction = instr_q;
    assign PR1_PC          = pr1_pc_q;
    assign PR1_valid       = valid_q;
    assign halted          = halted_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: reference model compared every cycle,
// plus literal expectations pinning the model on the directed scenarios.
module tb_if_stage;

    localparam int PCW = 12;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0;
    logic            branch_taken = 1'b0;
    logic [PCW-1:0]  branch_target = '0;
    logic            halt_req = 1'b0;
    logic [PCW-1:0]  imem_addr;
    logic [31:0]     imem_data;
    logic [31:0]     PR1_instruction;
    logic [PCW-1:0]  PR1_PC;
    logic            PR1_valid;
    logic            halted;

    int checks = 0;
    int errors = 0;

    if_stage #(.PC_LEN(PCW)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .halt_req        (halt_req),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .PR1_instruction (PR1_instruction),
        .PR1_PC          (PR1_PC),
        .PR1_valid       (PR1_valid),
        .halted          (halted)
    );

    always #5 clk = ~clk;

    // Memory image: mem[a] = a + 0x100
    assign imem_data = 32'(imem_addr) + 32'h100;

    // Reference model: 0 = boot, 1 = run, 2 = halt
    int  m_mode = 0;
    int  m_pc = 0;
    int  m_ipc = 0;
    int  m_instr = 0;
    bit  m_valid = 0;
    bit  m_on = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit s, input bit b,
                         input int t, input bit h);
        bit bub;
        bub = 0;
        if (r) begin
            m_pc = 0; bub = 1; m_mode = 0; m_on = 1;
        end else if (m_mode == 0) begin
            bub = 1; m_mode = 1;
        end else if (m_mode == 2) begin
            bub = 1;
        end else if (b) begin
            m_pc = t; bub = 1;
        end else if (h) begin
            bub = 1; m_mode = 2;
        end else if (!s) begin
            m_instr = m_pc + 'h100;
            m_ipc   = m_pc;
            m_valid = 1;
            m_pc    = (m_pc + 1) % (1 << PCW);
        end
        if (bub) begin
            m_instr = 0; m_ipc = 0; m_valid = 0;
        end
    endtask

    // One cycle: apply inputs, clock, advance the model.
    task automatic step(input bit r, input bit s, input bit b,
                        input int t, input bit h);
        rst = r; stall = s; branch_taken = b;
        branch_target = PCW'(t); halt_req = h;
        @(posedge clk);
        model(r, s, b, t, h);
        #1;
    endtask

    // Single compare process against the model.
    always @(negedge clk) begin
        if (m_on) begin
            chk("imem_addr", int'(imem_addr), m_pc);
            chk("PR1_instruction", int'(PR1_instruction), m_instr);
            chk("PR1_PC", int'(PR1_PC), m_ipc);
            chk("PR1_valid", int'(PR1_valid), int'(m_valid));
            chk("halted", int'(halted), int'(m_mode == 2));
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic lit_pr1(input string n, input int pc, input int ins,
                           input int v);
        chk({n, ".pc"}, int'(PR1_PC), pc);
        chk({n, ".ins"}, int'(PR1_instruction), ins);
        chk({n, ".v"}, int'(PR1_valid), v);
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 'h55, 1);
        lit_pr1("reset", 0, 0, 0);
        chk("reset.addr", int'(imem_addr), 0);
        chk("reset.halted", int'(halted), 0);

        // Boot bubble, then sequential fetch
        idle(1);
        lit_pr1("boot", 0, 0, 0);
        chk("boot.addr", int'(imem_addr), 0);
        idle(1); lit_pr1("f0", 0, 'h100, 1);
        idle(1); lit_pr1("f1", 1, 'h101, 1);
        idle(1); lit_pr1("f2", 2, 'h102, 1);
        idle(2);
        chk("pre_stall.addr", int'(imem_addr), 5);

        // Two-cycle stall at PC = 5
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0, 0);
            lit_pr1("stall", 4, 'h104, 1);
            chk("stall.addr", int'(imem_addr), 5);
        end
        idle(1); lit_pr1("resume", 5, 'h105, 1);

        // Branch wins over stall
        step(0, 1, 1, 'h3A, 0);
        lit_pr1("br", 0, 0, 0);
        chk("br.addr", int'(imem_addr), 'h3A);
        idle(1); lit_pr1("br_tgt", 'h3A, 'h13A, 1);

        // Wrap at all-ones
        step(0, 0, 1, 'hFFF, 0);
        idle(1);
        lit_pr1("wrap", 'hFFF, 'h10FF, 1);
        chk("wrap.addr", int'(imem_addr), 0);

        // Branch wins over halt_req
        step(0, 0, 1, 8, 1);
        chk("br_halt.halted", int'(halted), 0);
        idle(1); lit_pr1("at8", 8, 'h108, 1);
        step(0, 0, 1, 8, 0);

        // Halt at PC = 8 with stall ignored
        step(0, 1, 0, 0, 1);
        chk("halt.halted", int'(halted), 1);
        chk("halt.addr", int'(imem_addr), 8);
        lit_pr1("halt", 0, 0, 0);
        step(0, 0, 1, 'h20, 0);
        step(0, 1, 0, 0, 1);
        idle(2);
        chk("halt_br.addr", int'(imem_addr), 8);
        chk("halt_br.halted", int'(halted), 1);
        lit_pr1("halt_bub", 0, 0, 0);

        // Reset out of HALT
        step(1, 0, 0, 0, 0);
        chk("unhalt.halted", int'(halted), 0);
        chk("unhalt.addr", int'(imem_addr), 0);
        idle(1); lit_pr1("reboot", 0, 0, 0);
        idle(3); lit_pr1("refetch", 2, 'h102, 1);

        // Reset in the middle of a stall
        step(0, 1, 0, 0, 0);
        lit_pr1("pre_rst", 2, 'h102, 1);
        step(1, 1, 0, 0, 0);
        lit_pr1("rst_stall", 0, 0, 0);
        chk("rst_stall.addr", int'(imem_addr), 0);
        idle(2); lit_pr1("post", 0, 'h100, 1);

        // Scattered random traffic against the model
        for (int i = 0; i < 200; i++) begin
            step($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 7) == 0, int'($urandom_range(0, 4095)),
                 $urandom_range(0, 29) == 0);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
